load_store_unit: RTL and testbench

- Bus initiator between the CPU datapath and the word-wide memory interface, which decodes ROM/RAM/IO regions and has a synchronous read and a 32-bit write.
- Accepts byte, halfword and word load/store requests over a valid/ready handshake.
- Drives word-aligned mem_addr/mem_we/mem_wd and waits out the read latency.
- Performs read-modify-write for sub-word stores, and lane extraction plus sign/zero extension for loads.

---
 rtl/load_store_unit.sv | 267 ++++++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Bus initiator between the CPU datapath and a word-wide memory port with a
// synchronous read. Accepts byte/halfword/word loads and stores over a
// valid/ready handshake, drives a word-aligned memory address, waits out the
// read latency, performs read-modify-write for sub-word stores and lane
// extraction with sign/zero extension for loads.
//
// Parameters:
//   RD_LATENCY  cycles from mem_addr stable to mem_rd valid (>= 1)
//
// Optional build macro:
//   MISALIGN_TRAP_EN  when defined, misaligned halfword/word accesses are
//                     rejected with resp_err like an illegal width code.
//
// Ports:
//   clk         clock, rising edge
//   rst         synchronous active-high reset
//   req_valid   request present
//   req_ready   unit idle; accept when req_valid && req_ready
//   req_we      1 = store, 0 = load
//   req_funct3  RV32I width code (000 b, 001 h, 010 w, 100 bu, 101 hu)
//   req_addr    byte address
//   req_wd      store data, right-aligned
//   resp_valid  one-cycle completion pulse
//   resp_rd     extended load data (0 for stores)
//   resp_err    error flag, qualified by resp_valid
//   mem_we      memory write enable
//   mem_addr    word-aligned memory address
//   mem_wd      memory write data
//   mem_rd      memory read data
// -----------------------------------------------------------------------------
module load_store_unit #(
  parameter int RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wd,
  output logic        resp_valid,
  output logic [31:0] resp_rd,
  output logic        resp_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  localparam int CW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD_WAIT = 2'd1,
    S_WRITE   = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [2:0]    funct3_q, funct3_d;
  logic [1:0]    lane_q, lane_d;
  logic [15:0]   wd_q, wd_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wd_q, mem_wd_d;
  logic [31:0]   resp_rd_q, resp_rd_d;
  logic          resp_err_q, resp_err_d;

  // ---------------------------------------------------------------------------
  // Request decode (IDLE only)
  // ---------------------------------------------------------------------------
  logic legal;
  logic misalign;
  logic reject;

  always_comb begin
    legal = 1'b0;
    if (req_we) begin
      legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
              (req_funct3 == 3'b010);
    end else begin
      legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
              (req_funct3 == 3'b010) || (req_funct3 == 3'b100) ||
              (req_funct3 == 3'b101);
    end
  end

`ifdef MISALIGN_TRAP_EN
  // funct3[1:0] is the size for every legal code (00 b, 01 h, 10 w).
  assign misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                    ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign reject = !legal || misalign;

  // The read data captured in the final RD_WAIT cycle.
  logic rd_done;
  assign rd_done = (cnt_q == CW'(RD_LATENCY - 1));

  // ---------------------------------------------------------------------------
  // Load extraction from the live read word
  // ---------------------------------------------------------------------------
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;

  always_comb begin
    byte_sel = mem_rd[7:0];
    case (lane_q)
      2'd0: byte_sel = mem_rd[7:0];
      2'd1: byte_sel = mem_rd[15:8];
      2'd2: byte_sel = mem_rd[23:16];
      2'd3: byte_sel = mem_rd[31:24];
      default: byte_sel = mem_rd[7:0];
    endcase
    half_sel = lane_q[1] ? mem_rd[31:16] : mem_rd[15:0];

    load_data = mem_rd;
    case (funct3_q)
      3'b000: load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b100: load_data = {24'h0, byte_sel};
      3'b001: load_data = {{16{half_sel[15]}}, half_sel};
      3'b101: load_data = {16'h0, half_sel};
      default: load_data = mem_rd;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Store merge: per-byte select between captured store data and read word
  // ---------------------------------------------------------------------------
  logic [3:0]  be;
  logic [31:0] merged;

  always_comb begin
    be = 4'b1111;
    case (funct3_q[1:0])
      2'b00:   be = 4'b0001 << lane_q;
      2'b01:   be = lane_q[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_merge
      if ((gi % 2) == 1) begin : g_odd
        // Odd lanes take the upper half of a halfword store.
        assign merged[gi*8 +: 8] = be[gi] ? (funct3_q[0] ? wd_q[15:8] : wd_q[7:0])
                                          : mem_rd[gi*8 +: 8];
      end else begin : g_even
        assign merged[gi*8 +: 8] = be[gi] ? wd_q[7:0] : mem_rd[gi*8 +: 8];
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    funct3_d   = funct3_q;
    lane_d     = lane_q;
    wd_d       = wd_q;
    mem_addr_d = mem_addr_q;
    mem_wd_d   = mem_wd_q;
    resp_rd_d  = resp_rd_q;
    resp_err_d = resp_err_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d       = req_we;
          funct3_d   = req_funct3;
          lane_d     = req_addr[1:0];
          wd_d       = req_wd[15:0];
          cnt_d      = '0;
          resp_rd_d  = 32'h0;
          resp_err_d = 1'b0;
          if (reject) begin
            // No memory access at all; report the error next cycle.
            resp_err_d = 1'b1;
            state_d    = S_RESP;
          end else if (req_we && (req_funct3 == 3'b010)) begin
            mem_addr_d = {req_addr[31:2], 2'b00};
            mem_wd_d   = req_wd;
            state_d    = S_WRITE;
          end else begin
            mem_addr_d = {req_addr[31:2], 2'b00};
            state_d    = S_RD_WAIT;
          end
        end
      end

      S_RD_WAIT: begin
        if (rd_done) begin
          if (we_q) begin
            mem_wd_d = merged;
            state_d  = S_WRITE;
          end else begin
            resp_rd_d = load_data;
            state_d   = S_RESP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_WRITE: begin
        state_d = S_RESP;
      end

      S_RESP: begin
        resp_rd_d  = 32'h0;
        resp_err_d = 1'b0;
        state_d    = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      funct3_q   <= 3'b000;
      lane_q     <= 2'b00;
      wd_q       <= 16'h0;
      mem_addr_q <= 32'h0;
      mem_wd_q   <= 32'h0;
      resp_rd_q  <= 32'h0;
      resp_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      funct3_q   <= funct3_d;
      lane_q     <= lane_d;
      wd_q       <= wd_d;
      mem_addr_q <= mem_addr_d;
      mem_wd_q   <= mem_wd_d;
      resp_rd_q  <= resp_rd_d;
      resp_err_q <= resp_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: registers or state decodes only
  // ---------------------------------------------------------------------------
  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign mem_we     = (state_q == S_WRITE);
  assign mem_addr   = mem_addr_q;
  assign mem_wd     = mem_wd_q;
  assign resp_rd    = resp_rd_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wd;
  logic        resp_valid;
  logic [31:0] resp_rd;
  logic        resp_err;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  load_store_unit #(.RD_LATENCY(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wd     (req_wd),
    .resp_valid (resp_valid),
    .resp_rd    (resp_rd),
    .resp_err   (resp_err),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: registered address inside the DUT, one-cycle read latency.
  logic [31:0] mem [0:15];
  logic        pre_en;
  logic [3:0]  pre_idx;
  logic [31:0] pre_data;

  assign mem_rd = mem[mem_addr[5:2]];

  always @(posedge clk) begin
    if (pre_en)      mem[pre_idx] <= pre_data;
    else if (mem_we) mem[mem_addr[5:2]] <= mem_wd;
  end

  int tests_run;
  int tests_failed;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] init;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;   // cycles after accept until resp_valid
    int          exp_wk;    // cycle of the mem_we pulse, 0 = none
    logic [31:0] exp_wd;
  } vec_t;

  function automatic vec_t mk(input logic we, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic [31:0] init, input logic [31:0] exp_rd,
                              input logic exp_err, input int exp_lat,
                              input int exp_wk, input logic [31:0] exp_wd);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wd = wd; v.init = init;
    v.exp_rd = exp_rd; v.exp_err = exp_err; v.exp_lat = exp_lat;
    v.exp_wk = exp_wk; v.exp_wd = exp_wd;
    return v;
  endfunction

  // Observations of the last transaction
  int          got_wait, got_k, got_wcnt, got_wk;
  logic [31:0] got_rd, got_wd, got_waddr, got_maddr;
  logic        got_err;

  task automatic preload(input logic [31:0] addr, input logic [31:0] data);
    pre_en   = 1'b1;
    pre_idx  = addr[5:2];
    pre_data = data;
    @(posedge clk);
    #1 pre_en = 1'b0;
    @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge of the response cycle.
  task automatic run_txn(input vec_t v, input bit do_pre);
    bit done;
    if (do_pre) preload(v.addr, v.init);
    req_valid  = 1'b1;
    req_we     = v.we;
    req_funct3 = v.f3;
    req_addr   = v.addr;
    req_wd     = v.wd;
    got_wait   = 0;
    while (!req_ready && got_wait < 10) begin
      @(posedge clk);
      @(negedge clk);
      got_wait++;
    end
    @(posedge clk);            // accept edge
    @(negedge clk);
    // Scramble request inputs to prove they were captured.
    req_valid  = 1'b0;
    req_we     = ~v.we;
    req_funct3 = 3'b111;
    req_addr   = 32'hFFFF_FFFF;
    req_wd     = 32'h0;
    got_k = 0; got_wcnt = 0; got_wk = 0;
    got_rd = 32'h0; got_err = 1'b0; got_wd = 32'h0; got_waddr = 32'h0;
    got_maddr = mem_addr;
    done = 1'b0;
    for (int k = 1; k <= 12 && !done; k++) begin
      if (mem_we) begin
        got_wcnt++;
        got_wk    = k;
        got_wd    = mem_wd;
        got_waddr = mem_addr;
      end
      if (resp_valid) begin
        got_k   = k;
        got_rd  = resp_rd;
        got_err = resp_err;
        done    = 1'b1;
      end else begin
        @(posedge clk);
        @(negedge clk);
      end
    end
  endtask

  task automatic check_vec(input vec_t v, input int i);
    string p;
    p = $sformatf("v%0d", i);
    chk({p, ".lat"},  got_k,    v.exp_lat);
    chk({p, ".rd"},   got_rd,   v.exp_rd);
    chk({p, ".err"},  {31'h0, got_err}, {31'h0, v.exp_err});
    chk({p, ".wcnt"}, got_wcnt, (v.exp_wk != 0) ? 1 : 0);
    if (v.exp_wk != 0) begin
      chk({p, ".wcyc"},  got_wk,    v.exp_wk);
      chk({p, ".wd"},    got_wd,    v.exp_wd);
      chk({p, ".waddr"}, got_waddr, {v.addr[31:2], 2'b00});
      chk({p, ".memword"}, mem[v.addr[5:2]], v.exp_wd);
    end else if (!v.exp_err) begin
      chk({p, ".maddr"}, got_maddr, {v.addr[31:2], 2'b00});
    end
    $display("[TB] txn %0d we=%0b f3=%03b addr=%08h -> lat=%0d rd=%08h err=%0b writes=%0d",
             i, v.we, v.f3, v.addr, got_k, got_rd, got_err, got_wcnt);
  endtask

  localparam int NV = 17;
  vec_t vecs [NV];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wcount, rcount;
    tests_run = 0; tests_failed = 0;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wd = 32'h0;
    pre_en = 1'b0; pre_idx = 4'h0; pre_data = 32'h0;

    vecs[0]  = mk(1'b0, 3'b010, 32'h0010_0004, 32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 2, 0, 32'h0);
    vecs[1]  = mk(1'b0, 3'b000, 32'h0010_0003, 32'h0, 32'h8012_3456, 32'hFFFF_FF80, 1'b0, 2, 0, 32'h0);
    vecs[2]  = mk(1'b0, 3'b100, 32'h0010_0003, 32'h0, 32'h8012_3456, 32'h0000_0080, 1'b0, 2, 0, 32'h0);
    vecs[3]  = mk(1'b0, 3'b001, 32'h0010_0002, 32'h0, 32'h8012_3456, 32'hFFFF_8012, 1'b0, 2, 0, 32'h0);
    vecs[4]  = mk(1'b0, 3'b101, 32'h0010_0002, 32'h0, 32'h8012_3456, 32'h0000_8012, 1'b0, 2, 0, 32'h0);
    vecs[5]  = mk(1'b0, 3'b000, 32'h0010_0001, 32'h0, 32'h8012_3456, 32'h0000_0034, 1'b0, 2, 0, 32'h0);
    vecs[6]  = mk(1'b0, 3'b001, 32'h0010_0000, 32'h0, 32'h0000_F00D, 32'hFFFF_F00D, 1'b0, 2, 0, 32'h0);
    vecs[7]  = mk(1'b0, 3'b101, 32'h0010_0000, 32'h0, 32'h0000_F00D, 32'h0000_F00D, 1'b0, 2, 0, 32'h0);
    vecs[8]  = mk(1'b1, 3'b000, 32'h0010_0001, 32'hFFFF_FFAB, 32'h1122_3344, 32'h0, 1'b0, 3, 2, 32'h1122_AB44);
    vecs[9]  = mk(1'b1, 3'b000, 32'h0010_0007, 32'h0000_005A, 32'h1122_3344, 32'h0, 1'b0, 3, 2, 32'h5A22_3344);
    vecs[10] = mk(1'b1, 3'b001, 32'h0010_0002, 32'h1234_CAFE, 32'h1122_3344, 32'h0, 1'b0, 3, 2, 32'hCAFE_3344);
    vecs[11] = mk(1'b1, 3'b001, 32'h0010_0008, 32'h0000_BEEF, 32'h1122_3344, 32'h0, 1'b0, 3, 2, 32'h1122_BEEF);
    vecs[12] = mk(1'b1, 3'b010, 32'h0010_000C, 32'hA5A5_5A5A, 32'h0000_0000, 32'h0, 1'b0, 2, 1, 32'hA5A5_5A5A);
    vecs[13] = mk(1'b0, 3'b011, 32'h0010_0000, 32'h0, 32'h1234_5678, 32'h0, 1'b1, 1, 0, 32'h0);
    vecs[14] = mk(1'b0, 3'b110, 32'h0010_0004, 32'h0, 32'h1234_5678, 32'h0, 1'b1, 1, 0, 32'h0);
    vecs[15] = mk(1'b1, 3'b100, 32'h0010_0008, 32'h0000_00FF, 32'h1234_5678, 32'h0, 1'b1, 1, 0, 32'h0);
`ifdef MISALIGN_TRAP_EN
    vecs[16] = mk(1'b0, 3'b010, 32'h0010_0002, 32'h0, 32'h0BAD_F00D, 32'h0, 1'b1, 1, 0, 32'h0);
`else
    vecs[16] = mk(1'b0, 3'b010, 32'h0010_0002, 32'h0, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0, 2, 0, 32'h0);
`endif

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.req_ready",  {31'h0, req_ready},  32'h1);
    chk("rst.resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst.resp_rd",    resp_rd,             32'h0);
    chk("rst.resp_err",   {31'h0, resp_err},   32'h0);
    chk("rst.mem_we",     {31'h0, mem_we},     32'h0);
    chk("rst.mem_addr",   mem_addr,            32'h0);
    chk("rst.mem_wd",     mem_wd,              32'h0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      run_txn(vecs[i], 1'b1);
      check_vec(vecs[i], i);
    end

    // sh followed immediately by sw: the sw waits through RESP only.
    run_txn(vecs[10], 1'b1);
    check_vec(vecs[10], 100);
    begin
      vec_t sw;
      sw = mk(1'b1, 3'b010, 32'h0010_000C, 32'h1357_9BDF, 32'h0, 32'h0, 1'b0, 2, 1, 32'h1357_9BDF);
      run_txn(sw, 1'b0);
      chk("b2b.wait", got_wait, 1);
      check_vec(sw, 101);
    end

    // Reset during RD_WAIT of an sb: no write, no response.
    @(negedge clk);
    preload(32'h0010_0000, 32'h1122_3344);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
    req_addr = 32'h0010_0001; req_wd = 32'h0000_00AB;
    chk("rstmid.ready_before", {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rstmid.we_rdwait", {31'h0, mem_we}, 32'h0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid.ready_after", {31'h0, req_ready}, 32'h1);
    chk("rstmid.we_after",    {31'h0, mem_we},    32'h0);
    chk("rstmid.valid_after", {31'h0, resp_valid}, 32'h0);
    wcount = 0; rcount = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (mem_we) wcount++;
      if (resp_valid) rcount++;
    end
    chk("rstmid.no_write", wcount, 0);
    chk("rstmid.no_resp",  rcount, 0);
    chk("rstmid.memword",  mem[0], 32'h1122_3344);
    $display("[TB] txn rstmid sb aborted -> writes=%0d resps=%0d", wcount, rcount);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
